// File: rtl/logic_reduce_pipe.sv
// Bitwise NCH-channel reducer (AND/OR/XOR/NAND/NOR/XNOR/pass/accumulate-OR) with output change counter.
// Latency: 2 cycles from input transfer to o_valid; 1 beat/cycle throughput.
// Backpressure: valid/ready both sides; o_ready drops only when both stages are full and i_ready is low.
// Optional: define LRP_PARITY_EN to add o_par (XOR of o_data), registered alongside o_data.
module logic_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CNTW  = 16
) (
    input  logic                   CLK,
    input  logic                   RST_X,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [NCH*WIDTH-1:0]   i_data,
    input  logic [2:0]             i_op,
    input  logic                   i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_last,
    output logic [CNTW-1:0]        o_chg_cnt
`ifdef LRP_PARITY_EN
    ,
    output logic                   o_par
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_ACC  = 3'd7;
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_produce;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_s1_en;
    logic             w_s2_en;

    logic [WIDTH-1:0] r_acc;
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_dat;
    logic             r_s1_last;
    logic             r_o_vld;
    logic [WIDTH-1:0] r_o_dat;
    logic             r_o_last;
    logic [WIDTH-1:0] r_prev;
    logic [CNTW-1:0]  r_cnt;

    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        for (int k = 0; k < NCH; k++) begin
            w_and = w_and & i_data[k*WIDTH +: WIDTH];
            w_or  = w_or  | i_data[k*WIDTH +: WIDTH];
            w_xor = w_xor ^ i_data[k*WIDTH +: WIDTH];
        end
    end

    assign w_acc_next = r_acc | w_or;

    always_comb begin
        w_red = w_acc_next;
        case (i_op)
            OP_AND:  w_red = w_and;
            OP_OR:   w_red = w_or;
            OP_XOR:  w_red = w_xor;
            OP_NAND: w_red = ~w_and;
            OP_NOR:  w_red = ~w_or;
            OP_XNOR: w_red = ~w_xor;
            OP_PASS: w_red = i_data[WIDTH-1:0];
            default: w_red = w_acc_next;
        endcase
    end

    // Each stage may load when its successor is empty or draining this cycle.
    assign w_s2_en    = !r_o_vld || i_ready;
    assign w_s1_en    = !r_s1_vld || w_s2_en;
    assign o_ready    = !(r_s1_vld && r_o_vld && !i_ready);
    assign w_in_xfer  = i_valid && o_ready;
    assign w_out_xfer = r_o_vld && i_ready;
    assign w_produce  = (i_op != OP_ACC) || i_last;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_acc <= '0;
        end else if (w_in_xfer) begin
            if (i_op == OP_ACC && !i_last) begin
                r_acc <= w_acc_next;
            end else begin
                r_acc <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_s1_vld  <= 1'b0;
            r_s1_dat  <= '0;
            r_s1_last <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_vld <= w_in_xfer && w_produce;
            if (w_in_xfer && w_produce) begin
                r_s1_dat  <= w_red;
                r_s1_last <= (i_op == OP_ACC);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_o_vld  <= 1'b0;
            r_o_dat  <= '0;
            r_o_last <= 1'b0;
        end else if (w_s2_en) begin
            r_o_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_o_dat  <= r_s1_dat;
                r_o_last <= r_s1_last;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else if (w_out_xfer) begin
            r_prev <= r_o_dat;
            if (r_o_dat != r_prev && r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

`ifdef LRP_PARITY_EN
    logic r_par;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_par <= 1'b0;
        end else if (w_s2_en && r_s1_vld) begin
            r_par <= ^r_s1_dat;
        end
    end

    assign o_par = r_par;
`endif

    assign o_valid   = r_o_vld;
    assign o_data    = r_o_dat;
    assign o_last    = r_o_last;
    assign o_chg_cnt = r_cnt;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Scoreboard bench for logic_reduce_pipe: directed beats push expected results, a monitor pops on each output transfer.
module tb_logic_reduce_pipe;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         last;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST_X;
    logic            i_valid;
    logic            o_ready;
    logic [N*W-1:0]  i_data;
    logic [2:0]      i_op;
    logic            i_last;
    logic            o_valid;
    logic            i_ready;
    logic [W-1:0]    o_data;
    logic            o_last;
    logic [CW-1:0]   o_chg_cnt;
`ifdef LRP_PARITY_EN
    logic            o_par;
`endif

    exp_t            q[$];
    exp_t            m_e;
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [CW-1:0]   m_cnt;
    logic [W-1:0]    m_prev;
    bit              pend;

    always #5 CLK = ~CLK;

    logic_reduce_pipe #(.WIDTH(W), .NCH(N), .CNTW(CW)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_op      (i_op),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_last    (o_last),
        .o_chg_cnt (o_chg_cnt)
`ifdef LRP_PARITY_EN
        ,
        .o_par     (o_par)
`endif
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: pops one expected entry per output transfer; change-count checked the cycle after.
    always @(negedge CLK) begin
        if (!RST_X) begin
            m_cnt  = '0;
            m_prev = '0;
            pend   = 1'b0;
        end else begin
            if (pend) begin
                check("chg_cnt_track", 32'(o_chg_cnt), 32'(m_cnt));
                pend = 1'b0;
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h, no result expected (t=%0t)", o_data, $time);
                end else begin
                    m_e = q.pop_front();
                    check("out_data", 32'(o_data), 32'(m_e.dat));
                    check("out_last", 32'(o_last), 32'(m_e.last));
`ifdef LRP_PARITY_EN
                    check("out_par", 32'(o_par), 32'(^m_e.dat));
`endif
                end
                if (o_data != m_prev && m_cnt != '1) m_cnt = m_cnt + 1'b1;
                m_prev = o_data;
                pend   = 1'b1;
            end
        end
    end

    task automatic push(input logic [W-1:0] d, input logic l);
        exp_t e;
        e.dat  = d;
        e.last = l;
        q.push_back(e);
    endtask

    // Presents one beat and returns #1 after the edge on which it was accepted.
    task automatic send(input logic [N*W-1:0] d, input logic [2:0] op, input logic l);
        logic rdy;
        int   n;
        i_valid = 1'b1;
        i_data  = d;
        i_op    = op;
        i_last  = l;
        n = 0;
        do begin
            @(negedge CLK);
            rdy = o_ready;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: o_ready=0, expected 1 within 200 cycles");
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        repeat (2) @(posedge CLK);
        #1;
        check(nm, q.size(), 0);
    endtask

    task automatic do_reset(input int cyc);
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        RST_X   = 1'b0;
        repeat (cyc) @(posedge CLK);
        #1;
        RST_X = 1'b1;
    endtask

    logic [2:0] ops  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [7:0] exps [7] = '{8'h01, 8'hFF, 8'h96, 8'hFE, 8'h00, 8'h69, 8'h0F};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_X   = 1'b0;
        i_valid = 1'b1;
        i_data  = '1;
        i_op    = 3'd1;
        i_last  = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_o_valid", 32'(o_valid), 0);
        check("rst_o_data", 32'(o_data), 0);
        check("rst_chg_cnt", 32'(o_chg_cnt), 0);
        check("rst_o_ready", 32'(o_ready), 1);
        @(posedge CLK);
        #1;
        i_valid = 1'b0;
        RST_X   = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_idle", 32'(o_valid), 0);
        end

        // OR of one-hot channels with 2-cycle latency
        @(posedge CLK);
        #1;
        push(8'h0F, 1'b0);
        send(32'h08040201, 3'd1, 1'b0);
        @(negedge CLK);
        check("lat_cycle1_no_valid", 32'(o_valid), 0);
        @(negedge CLK);
        check("lat_cycle2_valid", 32'(o_valid), 1);
        check("lat_cycle2_data", 32'(o_data), 32'h0F);
        wait_drain("drain_or");
        check("or_chg_cnt", 32'(o_chg_cnt), 1);

        // Every operator on channels 0x0F,0x33,0x55,0xFF, back to back
        for (int i = 0; i < 7; i++) begin
            push(exps[i], 1'b0);
            send(32'hFF55330F, ops[i], 1'b0);
        end
        wait_drain("drain_ops");
        check("ops_chg_cnt", 32'(o_chg_cnt), 8);

        // Backpressure: two beats fill the pipe, third held until i_ready rises
        i_ready = 1'b0;
        push(8'hF0, 1'b0);
        push(8'h0F, 1'b0);
        push(8'hAA, 1'b0);
        send(32'hF0F0F0F0, 3'd0, 1'b0);
        send(32'h0F0F0F0F, 3'd0, 1'b0);
        i_valid = 1'b1;
        i_data  = 32'hAAAAAAAA;
        i_op    = 3'd0;
        repeat (2) begin
            @(negedge CLK);
            check("bp_o_ready_low", 32'(o_ready), 0);
            check("bp_o_valid_held", 32'(o_valid), 1);
            check("bp_o_data_held", 32'(o_data), 32'hF0);
        end
        @(posedge CLK);
        #1;
        i_ready = 1'b1;
        send(32'hAAAAAAAA, 3'd0, 1'b0);
        wait_drain("drain_bp");
        check("bp_chg_cnt", 32'(o_chg_cnt), 11);

        // Accumulate groups, restart from zero, partial group discarded by another op
        push(8'h91, 1'b1);
        send(32'h00000001, 3'd7, 1'b0);
        send(32'h00000010, 3'd7, 1'b0);
        send(32'h00000080, 3'd7, 1'b1);
        push(8'h02, 1'b1);
        send(32'h00000002, 3'd7, 1'b1);
        send(32'h00000040, 3'd7, 1'b0);
        push(8'h05, 1'b0);
        send(32'h00000401, 3'd1, 1'b1);
        push(8'h01, 1'b1);
        send(32'h00000001, 3'd7, 1'b1);
        wait_drain("drain_acc");

        // Change counter 1,1,2 from a fresh reset
        do_reset(2);
        push(8'h3C, 1'b0);
        send(32'h0000330F, 3'd2, 1'b0);
        wait_drain("drain_chg1");
        check("chg_first", 32'(o_chg_cnt), 1);
        push(8'h3C, 1'b0);
        send(32'h0000330F, 3'd2, 1'b0);
        wait_drain("drain_chg2");
        check("chg_repeat", 32'(o_chg_cnt), 1);
        push(8'h00, 1'b0);
        send(32'h00000000, 3'd2, 1'b0);
        wait_drain("drain_chg3");
        check("chg_to_zero", 32'(o_chg_cnt), 2);

        // Saturation: 20 alternating results must stop at all ones
        for (int i = 0; i < 20; i++) begin
            push((i % 2 == 1) ? 8'h01 : 8'h02, 1'b0);
            send((i % 2 == 1) ? 32'h00000001 : 32'h00000002, 3'd6, 1'b0);
        end
        wait_drain("drain_sat");
        check("chg_saturated", 32'(o_chg_cnt), 32'hF);
        push(8'h55, 1'b0);
        send(32'h00000055, 3'd6, 1'b0);
        wait_drain("drain_sat2");
        check("chg_sat_hold", 32'(o_chg_cnt), 32'hF);

        // Reset in the middle of an accumulate group
        send(32'h00000001, 3'd7, 1'b0);
        send(32'h00000002, 3'd7, 1'b0);
        do_reset(1);
        repeat (3) begin
            @(negedge CLK);
            check("rst_acc_no_output", 32'(o_valid), 0);
        end
        @(posedge CLK);
        #1;
        push(8'h07, 1'b0);
        send(32'h00040201, 3'd1, 1'b0);
        push(8'h04, 1'b1);
        send(32'h00000004, 3'd7, 1'b1);
        wait_drain("drain_rst_acc");
        check("rst_acc_chg_cnt", 32'(o_chg_cnt), 2);

        check("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_reduce_pipe.md
Name: logic_reduce_pipe

Overview:
- Parametrised, pipelined successor to the team's two-input combinational OR check block.
- Takes NCH channels of WIDTH bits and reduces them bitwise with a run-time selected operator (AND/OR/XOR/NAND/NOR/XNOR/pass/accumulate).
- Output is registered with a valid/ready handshake on both sides.
- Counts output value changes, replacing the print-on-change observation of earlier benches with a hardware counter.

Parameters:
- WIDTH, 8: bits per channel and of the result.
- NCH, 4: number of input channels; legal range 2..8.
- CNTW, 16: width of the change counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_X  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept an input beat.
- i_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- i_op  input  3  operator, sampled with the beat.
- i_last  input  1  ends an accumulate group; ignored for other ops.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_data  output  WIDTH  result.
- o_last  output  1  result closes an accumulate group; 0 for other ops.
- o_chg_cnt  output  CNTW  count of transferred results that differed from the previous transferred result.
- o_par  output  1  present only with LRP_PARITY_EN.

Behaviour:
- Reset (RST_X low, asynchronous): all of the following clear immediately and are independent of CLK.
  - Pipeline valids, o_valid, o_data, o_last, o_chg_cnt, accumulator, previous-result register and o_par clear to 0.
  - o_ready = 1 while in reset and after release.
- Reset asserted mid-operation drops every in-flight beat and any partial accumulation; nothing is replayed.
- Transfers: an input transfer occurs when i_valid && o_ready at a CLK edge; an output transfer when o_valid && i_ready.
- Operators (bitwise across all NCH channels): 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 pass channel 0, 7 accumulate-OR.
- Pipeline: two stages.
  - S1 registers the reduction result, op and last.
  - S2 is the output register (o_valid/o_data/o_last).
  - Latency is 2 cycles from input transfer to o_valid with no backpressure.
  - Throughput is 1 beat/cycle.
  - Each stage advances when its successor is empty or transferring in the same cycle.
  - o_ready = !(S1 valid && S2 valid && !i_ready); a combinational path from i_ready is permitted.
  - While stalled, o_data/o_last hold stable and o_valid stays high until transfer.
  - No beat is lost or duplicated; order is preserved.
- Accumulate (op 7):
  - acc_next = acc | OR(channels).
  - A beat with i_last=0 updates acc only; it produces no S1 entry but still requires o_ready.
  - A beat with i_last=1 produces result acc_next with last=1 and clears acc to 0.
  - A non-7 beat arriving with a partial acc discards acc (clears to 0) and is processed normally.
  - A single op-7 beat with i_last=1 outputs the OR of its channels.
- Change counter:
  - On each output transfer, if o_data != prev, o_chg_cnt increments; prev then takes o_data.
  - prev = 0 after reset, so a first result of 0 does not count.
  - The counter saturates at all ones and does not wrap.
- Simultaneous input and output transfer in one cycle with both stages full is legal and keeps both stages full.

Optional Feature:
- LRP_PARITY_EN defined: adds output o_par = XOR of o_data (odd parity bit), registered in S2 alongside o_data and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST_X=0 with i_valid=1 for 3 cycles -> o_valid=0, o_data=0x00, o_chg_cnt=0, o_ready=1; release -> no spurious output.
- OR with WIDTH=8, NCH=4, i_ready=1: channels 0x01,0x02,0x04,0x08, op=1 -> o_data=0x0F, o_last=0 exactly 2 cycles later; o_chg_cnt=1.
- Backpressure: i_ready=0, stream AND beats giving 0xF0,0x0F,0xAA -> o_ready=0 after 2 accepted and third held; raise i_ready -> outputs 0xF0,0x0F,0xAA in order, none dropped.
- Accumulate: op=7 beats with ch0=0x01, 0x10, 0x80 (last on third), other channels 0 -> single output 0x91 with o_last=1; next op-7 group starts from acc=0.
- Change count: XOR producing 0x3C twice, then 0x00 -> o_chg_cnt goes 1,1,2; 2^CNTW changes hold at all ones.
- Reset mid-accumulate plus parity (LRP_PARITY_EN): after 2 op-7 beats pulse RST_X -> no output; then OR giving 0x07 -> o_data=0x07, o_par=1.
